cavlc_rbsp_buffer: RTL

Bitstream aligner directly upstream of the CAVLC decoder top.
- Accepts 32-bit RBSP words (MSB-first) over a valid/ready handshake.
- Presents a 16-bit left-aligned lookahead window rbsp[0:15].
- Drops exactly len_comb bits per enabled cycle, as reported back by the decoder.
- Supports byte alignment for the end of slice data and trailing-bits handling.

---
 rtl/cavlc_rbsp_buffer_if.sv | 26 ++
 rtl/cavlc_rbsp_buffer.sv | 59 +++++
 2 files changed

// File: rtl/cavlc_rbsp_buffer_if.sv
// Stream-side and decoder-side signals of the RBSP aligner.
// The master is the word source plus the CAVLC decoder. The slave is the buffer.
interface cavlc_rbsp_buffer_if #(
  parameter int IN_W = 32
);
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            ena;
  logic [4:0]      len;
  logic            align;
  logic [0:15]     rbsp;
  logic            rbsp_valid;
  logic [6:0]      bit_count;
  logic            len_err;

  modport master (
    output in_data, in_valid, ena, len, align,
    input  in_ready, rbsp, rbsp_valid, bit_count, len_err
  );

  modport slave (
    input  in_data, in_valid, ena, len, align,
    output in_ready, rbsp, rbsp_valid, bit_count, len_err
  );
endinterface

// File: rtl/cavlc_rbsp_buffer.sv
// RBSP bitstream aligner: 64-bit left-aligned shift buffer that feeds a 16-bit lookahead
// window to the CAVLC decoder. It also supports consume, byte align and word insert in one cycle.
module cavlc_rbsp_buffer #(
  parameter int BUF_W = 64,
  parameter int IN_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  cavlc_rbsp_buffer_if.slave  bus
);
  localparam int CNT_W = 7;

  logic [BUF_W-1:0] sbuf, buf_nxt, ins;
  logic [CNT_W-1:0] bit_count, cnt_nxt, step, rem;
  logic [2:0]       bit_pos, pos_c, pad, pos_nxt;
  logic [4:0]       c;
  logic             consume, len_bad, load, len_err;
  logic             rbsp_valid, in_ready;

  assign rbsp_valid     = bit_count >= CNT_W'(16);
  assign in_ready       = (bit_count <= CNT_W'(IN_W)) && !rst;
  assign bus.rbsp       = sbuf[BUF_W-1 -: 16];
  assign bus.rbsp_valid = rbsp_valid;
  assign bus.in_ready   = in_ready;
  assign bus.bit_count  = bit_count;
  assign bus.len_err    = len_err;

  always_comb begin
    consume = bus.ena && rbsp_valid;
    len_bad = consume && (bus.len > 5'd16);
    c       = 5'd0;
    if (consume) c = len_bad ? 5'd16 : bus.len;
    pos_c   = bit_pos + c[2:0];
    // Modulo-8 negation gives the distance to the next byte boundary.
    pad     = bus.align ? (3'd0 - pos_c) : 3'd0;
    step    = {2'b00, c} + {4'b0000, pad};
    rem     = bit_count - step;
    load    = bus.in_valid && in_ready;
    // Load implies rem <= IN_W, so the word always lands fully inside the buffer.
    ins     = {bus.in_data, {(BUF_W-IN_W){1'b0}}} >> rem;
    buf_nxt = (sbuf << step) | (load ? ins : '0);
    cnt_nxt = rem + (load ? CNT_W'(IN_W) : '0);
    pos_nxt = pos_c + pad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf      <= '0;
      bit_count <= '0;
      bit_pos   <= '0;
      len_err   <= 1'b0;
    end else begin
      sbuf      <= buf_nxt;
      bit_count <= cnt_nxt;
      bit_pos   <= pos_nxt;
      if (len_bad) len_err <= 1'b1;
    end
  end
endmodule
